iomem_bellek_yanitlayici: RTL and testbench

- Responder (slave) end of the iomem bus that the processor drives toward main memory.
- Accepts one request at a time: valid, wstrb, addr, wdata.
- Performs a word read or a byte-masked write on an internal 32-bit word array after a fixed, programmable latency, then pulses ready with rdata.
- Serves as the main-memory model behind the processor top in simulation, and as the on-chip RAM front end in integration.

---
 rtl/iomem_bellek_yanitlayici_if.sv | 20 ++
 rtl/iomem_bellek_yanitlayici.sv | 116 +++++++++++
 tb/tb_iomem_bellek_yanitlayici.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_bellek_yanitlayici_if.sv
// iomem request/response bundle between the processor (master) and a memory
// responder (slave). The initiator holds every request field stable until ready.
interface iomem_bellek_yanitlayici_if;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/iomem_bellek_yanitlayici.sv
// iomem responder backed by a 32-bit word array: one request at a time, fixed
// programmable latency, registered one-cycle ready/hata pulses.
module iomem_bellek_yanitlayici #(
  parameter int          ADRES_GENISLIK  = 10,
  parameter int          GECIKME         = 2,
  parameter logic [31:0] BASLANGIC_ADRES = 32'h4000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  iomem_bellek_yanitlayici_if.slave   iomem,
  output logic                        hata_o
);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  localparam logic [31:0] TABAN    = BASLANGIC_ADRES;
  localparam logic [3:0]  SAYAC_YUK = 4'(GECIKME - 1);

  durum_t                    durum_q, durum_d;
  logic [3:0]                sayac_q, sayac_d;
  logic                      tamamla;
  logic                      aralikta;
  logic                      okuma;
  logic                      yaz_en;
  logic [ADRES_GENISLIK-1:0] kelime;
  logic                      ready_q;
  logic                      hata_q;
  logic [31:0]               rdata_q;
  logic [31:0]               mem [2**ADRES_GENISLIK];
  logic                      unused_adres_lsb;

  // Base is aligned to the array size, so the range test is a compare of the
  // upper address bits and the word index is simply the bits just above them.
  assign aralikta = (iomem.addr[31:ADRES_GENISLIK+2] == TABAN[31:ADRES_GENISLIK+2]);
  assign kelime   = iomem.addr[ADRES_GENISLIK+1:2];
  assign okuma    = (iomem.wstrb == 4'b0000);
  assign yaz_en   = tamamla && aralikta && !okuma;

  assign unused_adres_lsb = ^iomem.addr[1:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
      sayac_q <= 4'd0;
    end else begin
      durum_q <= durum_d;
      sayac_q <= sayac_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    tamamla = 1'b0;
    unique case (durum_q)
      BOSTA: begin
        if (iomem.valid) begin
          sayac_d = SAYAC_YUK;
          if (GECIKME == 1) tamamla = 1'b1;
          else              durum_d = BEKLE;
        end
      end
      BEKLE: begin
        if (!iomem.valid) begin
          // Request withdrawn before completion: drop it without side effects.
          durum_d = BOSTA;
          sayac_d = 4'd0;
        end else if (sayac_q == 4'd1) begin
          sayac_d = 4'd0;
          tamamla = 1'b1;
        end else begin
          sayac_d = sayac_q - 4'd1;
        end
      end
      YANIT: begin
        // valid seen here still belongs to the request just answered.
        durum_d = BOSTA;
      end
      default: begin
        durum_d = BOSTA;
        sayac_d = 4'd0;
      end
    endcase
    if (tamamla) durum_d = YANIT;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_q <= 1'b0;
      hata_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= tamamla;
      hata_q  <= tamamla && !aralikta;
      rdata_q <= (tamamla && aralikta && okuma) ? mem[kelime] : 32'd0;
    end
  end

  // Array contents survive reset; only enabled byte lanes are written.
  always_ff @(posedge clk_i) begin
    if (yaz_en) begin
      for (int n = 0; n < 4; n++) begin
        if (iomem.wstrb[n]) mem[kelime][8*n +: 8] <= iomem.wdata[8*n +: 8];
      end
    end
  end

  assign iomem.ready = ready_q;
  assign iomem.rdata = rdata_q;
  assign hata_o      = hata_q;

endmodule

// File: tb/tb_iomem_bellek_yanitlayici.sv
// Directed bench for iomem_bellek_yanitlayici: table of transactions on a
// GECIKME=2 instance plus hand sequences and GECIKME=1/15 instances.
module tb_iomem_bellek_yanitlayici;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  sel;
  logic        rdy;
  logic [31:0] rdat;
  logic        hata;
  logic        hata2, hata1, hata15;

  int tests_run;
  int tests_failed;

  iomem_bellek_yanitlayici_if bus2 ();
  iomem_bellek_yanitlayici_if bus1 ();
  iomem_bellek_yanitlayici_if bus15 ();

  assign bus2.valid  = valid && (sel == 2'd0);
  assign bus1.valid  = valid && (sel == 2'd1);
  assign bus15.valid = valid && (sel == 2'd2);
  assign bus2.wstrb  = wstrb;  assign bus1.wstrb = wstrb;  assign bus15.wstrb = wstrb;
  assign bus2.addr   = addr;   assign bus1.addr  = addr;   assign bus15.addr  = addr;
  assign bus2.wdata  = wdata;  assign bus1.wdata = wdata;  assign bus15.wdata = wdata;

  iomem_bellek_yanitlayici #(.ADRES_GENISLIK(10), .GECIKME(2), .BASLANGIC_ADRES(32'h4000_0000))
    dut2 (.clk_i(clk), .rst_i(rst_n), .iomem(bus2), .hata_o(hata2));
  iomem_bellek_yanitlayici #(.ADRES_GENISLIK(10), .GECIKME(1), .BASLANGIC_ADRES(32'h4000_0000))
    dut1 (.clk_i(clk), .rst_i(rst_n), .iomem(bus1), .hata_o(hata1));
  iomem_bellek_yanitlayici #(.ADRES_GENISLIK(10), .GECIKME(15), .BASLANGIC_ADRES(32'h4000_0000))
    dut15 (.clk_i(clk), .rst_i(rst_n), .iomem(bus15), .hata_o(hata15));

  always_comb begin
    rdy  = bus2.ready;
    rdat = bus2.rdata;
    hata = hata2;
    if (sel == 2'd1) begin
      rdy = bus1.ready; rdat = bus1.rdata; hata = hata1;
    end else if (sel == 2'd2) begin
      rdy = bus15.ready; rdat = bus15.rdata; hata = hata15;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_hata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One request; lat = posedges from the sampling edge to the ready cycle, -1 if none.
  task automatic txn(input logic [3:0] ws, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic h);
    @(negedge clk);
    valid = 1'b1; wstrb = ws; addr = a; wdata = d;
    lat = -1; rd = 32'hxxxx_xxxx; h = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rdy) begin
        lat = k; rd = rdat; h = hata;
        break;
      end
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          k;
    int          seen;
    logic [31:0] rd;
    logic        h;

    tests_run = 0; tests_failed = 0;
    valid = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; sel = 2'd0;

    vecs[0]  = '{4'hF, 32'h4000_0010, 32'hA5A5_1234, 32'h0000_0000, 1'b0};
    vecs[1]  = '{4'h0, 32'h4000_0010, 32'h0000_0000, 32'hA5A5_1234, 1'b0};
    vecs[2]  = '{4'hF, 32'h4000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[3]  = '{4'h5, 32'h4000_0020, 32'hFFEE_DDCC, 32'h0000_0000, 1'b0};
    vecs[4]  = '{4'h0, 32'h4000_0020, 32'h0000_0000, 32'h11EE_33CC, 1'b0};
    vecs[5]  = '{4'hF, 32'h4000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{4'h0, 32'h3FFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{4'hF, 32'h4000_1000, 32'h0123_4567, 32'h0000_0000, 1'b1};
    vecs[8]  = '{4'h0, 32'h4000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{4'h0, 32'h4000_0013, 32'h0000_0000, 32'hA5A5_1234, 1'b0};
    vecs[10] = '{4'hF, 32'h4000_0FFC, 32'h5555_AAAA, 32'h0000_0000, 1'b0};
    vecs[11] = '{4'h8, 32'h4000_0010, 32'h7700_0000, 32'h0000_0000, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_g2",  {31'd0, bus2.ready},  32'd0);
    chk("reset_rdata_g2",  bus2.rdata,           32'd0);
    chk("reset_hata_g2",   {31'd0, hata2},       32'd0);
    chk("reset_ready_g1",  {31'd0, bus1.ready},  32'd0);
    chk("reset_ready_g15", {31'd0, bus15.ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].wstrb, vecs[i].addr, vecs[i].wdata, lat, rd, h);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_rdata", i),   rd,       vecs[i].exp_rdata);
      chk($sformatf("vec%0d_hata", i),    {31'd0, h}, {31'd0, vecs[i].exp_hata});
    end
    txn(4'h0, 32'h4000_0FFC, 32'h0, lat, rd, h);
    chk("last_word_rdata", rd, 32'h5555_AAAA);
    txn(4'h0, 32'h4000_0010, 32'h0, lat, rd, h);
    chk("msb_strobe_rdata", rd, 32'h77A5_1234);

    // Back-to-back reads with valid held high across the response cycle.
    @(negedge clk);
    valid = 1'b1; wstrb = 4'h0; addr = 32'h4000_0010;
    seen = 0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rdy) begin seen = 1; break; end
    end
    chk("b2b_first_seen",  32'(seen), 32'd1);
    chk("b2b_first_rdata", rdat,      32'h77A5_1234);
    @(posedge clk); #1;
    chk("b2b_gap_ready", {31'd0, rdy}, 32'd0);
    addr = 32'h4000_0020;
    seen = 0;
    for (k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rdy) begin seen = k; break; end
    end
    chk("b2b_spacing",      32'(seen), 32'd3);
    chk("b2b_second_rdata", rdat,      32'h11EE_33CC);
    @(negedge clk);
    valid = 1'b0;

    // Withdrawn write leaves the word untouched and produces no ready.
    txn(4'hF, 32'h4000_0030, 32'h1357_9BDF, lat, rd, h);
    @(negedge clk);
    valid = 1'b1; wstrb = 4'hF; addr = 32'h4000_0030; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    valid = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy || hata) seen++;
    end
    chk("withdraw_no_ready", 32'(seen), 32'd0);
    txn(4'h0, 32'h4000_0030, 32'h0, lat, rd, h);
    chk("withdraw_word_kept", rd, 32'h1357_9BDF);

    // Reset in BEKLE: write lost, outputs held at zero.
    txn(4'hF, 32'h4000_0040, 32'h0BAD_F00D, lat, rd, h);
    @(negedge clk);
    valid = 1'b1; wstrb = 4'hF; addr = 32'h4000_0040; wdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_bekle_ready", {31'd0, rdy}, 32'd0);
    chk("rst_bekle_rdata", rdat,         32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(4'h0, 32'h4000_0040, 32'h0, lat, rd, h);
    chk("rst_after_latency", 32'(lat), 32'd2);
    chk("rst_write_lost",    rd,        32'h0BAD_F00D);

    // Reset during the response cycle clears ready/rdata without a clock edge.
    @(negedge clk);
    valid = 1'b1; wstrb = 4'h0; addr = 32'h4000_0000;
    seen = 0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rdy) begin seen = 1; break; end
    end
    chk("rst_async_pre_rdata", rdat, 32'hDEAD_BEEF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ready", {31'd0, rdy}, 32'd0);
    chk("rst_async_rdata", rdat,         32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Latency sweep and address LSB masking.
    sel = 2'd1;
    txn(4'hF, 32'h4000_0104, 32'hCAFE_0001, lat, rd, h);
    chk("g1_write_latency", 32'(lat), 32'd1);
    txn(4'h0, 32'h4000_0107, 32'h0, lat, rd, h);
    chk("g1_read_latency", 32'(lat), 32'd1);
    chk("g1_read_rdata",   rd,        32'hCAFE_0001);
    sel = 2'd2;
    txn(4'hF, 32'h4000_0200, 32'hBEEF_0015, lat, rd, h);
    chk("g15_write_latency", 32'(lat), 32'd15);
    txn(4'h0, 32'h4000_0203, 32'h0, lat, rd, h);
    chk("g15_read_latency", 32'(lat), 32'd15);
    chk("g15_read_rdata",   rd,        32'hBEEF_0015);
    sel = 2'd0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
